// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives a ready/valid instruction memory and fills the IF/ID register.
// Uses a one-entry skid buffer for stalls and a redirect register for redirects that arrive while a request is still pending.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        pcsrc,
    input  logic [31:0] pctarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pcd,
    output logic [31:0] pcplus4d,
    output logic        validd
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        KILL  = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [31:0] RESET_ADDR = RESET_PC & 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    state_t      r_state;
    state_t      w_state_nx;
    logic [31:0] r_areg;
    logic [31:0] w_areg_nx;
    logic [31:0] r_redir;
    logic [31:0] w_redir_nx;
    logic [31:0] r_skid_instr;
    logic [31:0] w_skid_instr_nx;
    logic [31:0] r_skid_pc;
    logic [31:0] w_skid_pc_nx;
    logic [31:0] r_instr;
    logic [31:0] r_pcd;
    logic [31:0] r_pcplus4d;
    logic [31:0] w_load_instr;
    logic [31:0] w_load_pc;
    logic        r_validd;
    logic        w_validd_nx;
    logic        r_imem_req;
    logic        w_hs;
    logic        w_load;
    logic        w_kill;

    // Next-state, next-address and IF/ID load decisions; pcsrc outranks flush, which outranks stall
    always_comb begin
        w_state_nx      = r_state;
        w_areg_nx       = r_areg;
        w_redir_nx      = r_redir;
        w_skid_instr_nx = r_skid_instr;
        w_skid_pc_nx    = r_skid_pc;
        w_load          = 1'b0;
        w_load_instr    = r_instr;
        w_load_pc       = r_pcd;
        w_kill          = flush;
        // A response only counts against a request we are actually driving
        w_hs            = r_imem_req & imem_ready;

        case (r_state)
            FETCH: begin
                if (pcsrc) begin
                    w_kill = 1'b1;
                    if (w_hs || !r_imem_req) begin
                        w_areg_nx = word_align(pctarget);
                    end else begin
                        w_redir_nx = word_align(pctarget);
                        w_state_nx = KILL;
                    end
                end else if (w_hs) begin
                    if (stall) begin
                        w_skid_instr_nx = imem_rdata;
                        w_skid_pc_nx    = r_areg;
                        w_state_nx      = HOLD;
                    end else begin
                        w_load       = 1'b1;
                        w_load_instr = imem_rdata;
                        w_load_pc    = r_areg;
                        w_areg_nx    = word_align(r_areg + 32'd4);
                    end
                end else begin
                    w_state_nx = FETCH;
                end
            end
            HOLD: begin
                if (pcsrc) begin
                    w_kill     = 1'b1;
                    w_areg_nx  = word_align(pctarget);
                    w_state_nx = FETCH;
                end else if (!stall) begin
                    w_load       = 1'b1;
                    w_load_instr = r_skid_instr;
                    w_load_pc    = r_skid_pc;
                    w_areg_nx    = word_align(r_skid_pc + 32'd4);
                    w_state_nx   = FETCH;
                end else begin
                    w_state_nx = HOLD;
                end
            end
            KILL: begin
                if (pcsrc) begin
                    w_kill     = 1'b1;
                    w_redir_nx = word_align(pctarget);
                end else begin
                    w_redir_nx = r_redir;
                end
                if (w_hs) begin
                    w_areg_nx  = w_redir_nx;
                    w_state_nx = FETCH;
                end else begin
                    w_state_nx = KILL;
                end
            end
            default: begin
                w_state_nx = FETCH;
            end
        endcase

        if (w_kill) begin
            w_validd_nx = 1'b0;
        end else if (w_load) begin
            w_validd_nx = 1'b1;
        end else begin
            w_validd_nx = r_validd;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Address, buffers, request flag and IF/ID register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_areg       <= RESET_ADDR;
            r_redir      <= 32'h0000_0000;
            r_skid_instr <= 32'h0000_0000;
            r_skid_pc    <= 32'h0000_0000;
            r_imem_req   <= 1'b0;
            r_instr      <= NOP_INSTR;
            r_pcd        <= 32'h0000_0000;
            r_pcplus4d   <= 32'h0000_0000;
            r_validd     <= 1'b0;
        end else begin
            r_areg       <= w_areg_nx;
            r_redir      <= w_redir_nx;
            r_skid_instr <= w_skid_instr_nx;
            r_skid_pc    <= w_skid_pc_nx;
            r_imem_req   <= (w_state_nx != HOLD);
            r_validd     <= w_validd_nx;
            if (w_load) begin
                r_instr    <= w_load_instr;
                r_pcd      <= w_load_pc;
                r_pcplus4d <= w_load_pc + 32'd4;
            end else begin
                r_instr    <= r_instr;
                r_pcd      <= r_pcd;
                r_pcplus4d <= r_pcplus4d;
            end
        end
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_areg;
    assign instr     = r_instr;
    assign pcd       = r_pcd;
    assign pcplus4d  = r_pcplus4d;
    assign validd    = r_validd;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random traffic,
// all compared against a transaction-level reference model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        pcsrc;
    logic [31:0] pctarget;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pcplus4d;
    logic        validd;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush      (flush),
        .pcsrc      (pcsrc),
        .pctarget   (pctarget),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .pcd        (pcd),
        .pcplus4d   (pcplus4d),
        .validd     (validd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: what is requested, what is parked, and what IF/ID holds
    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
    } parked_t;

    parked_t     m_parked[$];
    logic [31:0] m_addr;
    logic        m_req;
    logic        m_redir_v;
    logic [31:0] m_redir;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    logic [31:0] m_pc4;
    logic        m_valid;

    function automatic logic [31:0] tagw(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    task automatic model_reset();
        m_parked.delete();
        m_addr    = RESET_PC & 32'hFFFF_FFFC;
        m_req     = 1'b0;
        m_redir_v = 1'b0;
        m_redir   = 32'h0000_0000;
        m_instr   = NOP;
        m_pcd     = 32'h0000_0000;
        m_pc4     = 32'h0000_0000;
        m_valid   = 1'b0;
    endtask

    task automatic model_step();
        logic    hs;
        logic    loaded;
        parked_t e;
        hs     = m_req && imem_ready;
        loaded = 1'b0;
        if (pcsrc) begin
            m_valid = 1'b0;
            if (m_parked.size() > 0) begin
                m_parked.delete();
                m_addr = pctarget & 32'hFFFF_FFFC;
            end else if (m_redir_v) begin
                if (hs) begin
                    m_addr    = pctarget & 32'hFFFF_FFFC;
                    m_redir_v = 1'b0;
                end else begin
                    m_redir = pctarget & 32'hFFFF_FFFC;
                end
            end else if (hs || !m_req) begin
                m_addr = pctarget & 32'hFFFF_FFFC;
            end else begin
                m_redir_v = 1'b1;
                m_redir   = pctarget & 32'hFFFF_FFFC;
            end
        end else begin
            if (m_redir_v) begin
                if (hs) begin
                    m_addr    = m_redir;
                    m_redir_v = 1'b0;
                end
            end else if (m_parked.size() > 0) begin
                if (!stall) begin
                    e       = m_parked.pop_front();
                    m_instr = e.ins;
                    m_pcd   = e.pc;
                    m_pc4   = e.pc + 32'd4;
                    m_addr  = e.pc + 32'd4;
                    loaded  = 1'b1;
                end
            end else if (hs) begin
                if (stall) begin
                    m_parked.push_back('{ins: imem_rdata, pc: m_addr});
                end else begin
                    m_instr = imem_rdata;
                    m_pcd   = m_addr;
                    m_pc4   = m_addr + 32'd4;
                    m_addr  = m_addr + 32'd4;
                    loaded  = 1'b1;
                end
            end
            if (flush) begin
                m_valid = 1'b0;
            end else if (loaded) begin
                m_valid = 1'b1;
            end
        end
        m_req = (m_parked.size() == 0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("imem_req", {31'd0, imem_req}, {31'd0, m_req});
        chk("imem_addr", imem_addr, m_addr);
        chk("validd", {31'd0, validd}, {31'd0, m_valid});
        chk("instr", instr, m_instr);
        chk("pcd", pcd, m_pcd);
        chk("pcplus4d", pcplus4d, m_pc4);
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare #1 later
    task automatic cycle(input logic s, input logic f, input logic p,
                         input logic [31:0] t, input logic rdy);
        stall      = s;
        flush      = f;
        pcsrc      = p;
        pctarget   = t;
        imem_ready = rdy;
        imem_rdata = (rdy && m_req) ? tagw(m_addr) : $urandom();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        stall      = 1'b0;
        flush      = 1'b0;
        pcsrc      = 1'b0;
        pctarget   = 32'h0000_0000;
        imem_ready = 1'b1;
        imem_rdata = 32'h0000_0000;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all();
        chk("rst_instr_nop", instr, NOP);
        chk("rst_req_low", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Streaming from RESET_PC
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("stream_first_req", {31'd0, imem_req}, 32'd1);
        chk("stream_first_addr", imem_addr, 32'h0000_0000);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("stream_i0", instr, tagw(32'h0));
        chk("stream_v0", {31'd0, validd}, 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("stream_i4", instr, tagw(32'h4));

        // Stall while the 0x8 response arrives
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("hold_req_low", {31'd0, imem_req}, 32'd0);
        chk("hold_keeps_i4", instr, tagw(32'h4));
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("hold_still_i4", pcd, 32'h4);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("unstall_i8", instr, tagw(32'h8));
        chk("unstall_next_c", imem_addr, 32'h0000_000C);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect while the 0x10 request waits
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0);
        chk("kill_addr_held", imem_addr, 32'h0000_0010);
        chk("kill_valid_low", {31'd0, validd}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("kill_addr_held2", imem_addr, 32'h0000_0010);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("kill_next_200", imem_addr, 32'h0000_0200);
        chk("kill_dropped", {31'd0, validd}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("redir_i200", instr, tagw(32'h200));

        // Flush together with stall
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("flush_valid_low", {31'd0, validd}, 32'd0);
        chk("flush_areg_same", imem_addr, 32'h0000_0204);

        // Unaligned redirect target near the top of memory, then wrap
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
        chk("align_fffc", imem_addr, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_addr0", imem_addr, 32'h0000_0000);
        chk("wrap_pc4", pcplus4d, 32'h0000_0000);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Asynchronous reset between edges while in KILL
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0300, 1'b0);
        chk("pre_reset_kill_addr", imem_addr, 32'h0000_0004);
        #2;
        reset      = 1'b1;
        pcsrc      = 1'b0;
        imem_ready = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("async_addr", imem_addr, RESET_PC);
        chk("async_instr", instr, NOP);
        @(posedge clk);
        #1;
        chk("in_reset_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("post_reset_addr", imem_addr, RESET_PC);
        chk("post_reset_valid", {31'd0, validd}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 1),
                  ($urandom_range(0, 9) < 1), $urandom(), ($urandom_range(0, 9) < 6));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port stall  input  1  decode stage cannot accept a new instruction this cycle.
REQ-005 SHALL have port flush  input  1  kill the instruction currently held in the IF/ID register.
REQ-006 SHALL have port pcsrc  input  1  redirect request (taken branch/jump).
REQ-007 SHALL have port pctarget  input  32  redirect address.
REQ-008 SHALL have port imem_req  output  1  instruction memory request valid.
REQ-009 SHALL have port imem_addr  output  32  instruction memory word address.
REQ-010 SHALL have port imem_ready  input  1  memory returns imem_rdata for the pending request this cycle.
REQ-011 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-012 SHALL have port instr  output  32  IF/ID instruction, consumed by decode and the immediate extender.
REQ-013 SHALL have port pcd  output  32  IF/ID PC of instr.
REQ-014 SHALL have port pcplus4d  output  32  IF/ID pcd+4.
REQ-015 SHALL have port validd  output  1  instr/pcd/pcplus4d hold a live instruction.

Function
REQ-016 SHALL keep FSM states FETCH, HOLD, KILL; reset state FETCH.
REQ-017 SHALL drive imem_addr from an internal address register areg, never combinationally from inputs.
REQ-018 SHALL force bits [1:0] of every loaded address (RESET_PC, pc+4, pctarget) to 2'b00.
REQ-019 FETCH: imem_req=1; imem_addr and imem_req held stable until imem_ready=1.
REQ-020 FETCH, imem_ready=1, stall=0, pcsrc=0: IF/ID loads instr=imem_rdata, pcd=areg, pcplus4d=areg+4, validd=1; areg<=areg+4; next request issued the following cycle (one response per cycle sustained).
REQ-021 FETCH, imem_ready=1, stall=1, pcsrc=0: capture imem_rdata/areg into a one-entry skid buffer, IF/ID unchanged, go HOLD.
REQ-022 HOLD: imem_req=0; when stall=0, move skid buffer into IF/ID (validd=1), areg<=buffered address+4, go FETCH.
REQ-023 pcsrc=1 with imem_ready=1 or in HOLD: discard response/buffer, areg<=pctarget, validd<=0, go FETCH.
REQ-024 pcsrc=1 in FETCH with imem_ready=0: keep imem_req=1 and old imem_addr, store pctarget in a redirect register, validd<=0, go KILL.
REQ-025 KILL: imem_req=1 with old address; on imem_ready=1 drop the data, areg<=redirect register, go FETCH; a new pcsrc in KILL overwrites the redirect register (latest wins).
REQ-026 flush=1: validd<=0 next edge regardless of stall; does not change areg or FSM state.
REQ-027 Priority: reset > pcsrc > flush > stall; stall never blocks redirect or flush.
REQ-028 While stall=1 and no redirect, IF/ID outputs SHALL hold their values exactly.
REQ-029 areg+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no error flag.
REQ-030 imem_rdata SHALL be ignored when imem_ready=0 or imem_req=0.

Reset
REQ-031 On reset=1, immediately and asynchronously: state FETCH, areg=RESET_PC, validd=0, instr=32'h0000_0013 (NOP), pcd=0, pcplus4d=0, skid buffer and redirect register cleared.
REQ-032 During reset imem_req=0; first request, to RESET_PC, appears in the first cycle after reset deasserts.
REQ-033 Reset asserted mid-handshake (FETCH or KILL) SHALL abandon the outstanding request; its later imem_ready is ignored until a new request is issued.

Verification
REQ-034 Streaming: imem_ready=1 every cycle, rdata=addr-tagged words -> instr sequence for 0x0,0x4,0x8,0xC on consecutive cycles, validd=1 from second cycle after reset release.
REQ-035 Stall: stall=1 for 3 cycles while response for 0x8 arrives -> HOLD entered, imem_req=0, IF/ID keeps 0x4 instruction, 0x8 instruction appears one cycle after stall drops, next request 0xC.
REQ-036 Redirect in wait: imem_ready=0 at 0x10, pcsrc=1 pctarget=0x200 -> imem_addr stays 0x10 until ready, that data dropped, next request 0x200, validd=0 in between.
REQ-037 Flush plus stall: flush=1 and stall=1 same cycle -> validd=0 next edge, areg unchanged.
REQ-038 Wrap and alignment: pctarget=32'hFFFF_FFFE -> request 32'hFFFF_FFFC, then 32'h0000_0000.
REQ-039 Async reset: assert reset between clock edges during KILL -> outputs take reset values before the next edge, first request after release is RESET_PC.
